// File: rtl/gp_register_bank.sv
// General-purpose registers R0-R3 and program counter for the RISC-SPM datapath.
// Optional macro MULTI_LOAD_CHECK_EN blocks multi-register writes and flags illegal strobes in load_err.
module gp_register_bank #(
    parameter int unsigned word_size    = 8,
    parameter int unsigned pc_reset_val = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] data_in,
    input  logic                 Load_R0,
    input  logic                 Load_R1,
    input  logic                 Load_R2,
    input  logic                 Load_R3,
    input  logic                 Load_PC,
    input  logic                 Inc_PC,
    output logic [word_size-1:0] R0_out,
    output logic [word_size-1:0] R1_out,
    output logic [word_size-1:0] R2_out,
    output logic [word_size-1:0] R3_out,
    output logic [word_size-1:0] PC_count,
    output logic                 pc_wrap,
    output logic                 load_err
);

    localparam logic [word_size-1:0] pc_init  = word_size'(pc_reset_val);
    localparam logic [word_size-1:0] all_ones = '1;

    logic [word_size-1:0] regs [4];
    logic [3:0]           load_vec;
    logic [3:0]           wr_en;

    assign load_vec = {Load_R3, Load_R2, Load_R1, Load_R0};

`ifdef MULTI_LOAD_CHECK_EN
    logic multi_load;
    logic err_set;

    // Any two of the four strobes high at once counts as a collision.
    assign multi_load = (Load_R0 & (Load_R1 | Load_R2 | Load_R3)) |
                        (Load_R1 & (Load_R2 | Load_R3)) |
                        (Load_R2 & Load_R3);
    assign wr_en      = multi_load ? 4'b0000 : load_vec;
    assign err_set    = multi_load | (Load_PC & Inc_PC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_err <= 1'b0;
        end else if (err_set) begin
            load_err <= 1'b1;
        end
    end
`else
    assign wr_en    = load_vec;
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= data_in;
                end
            end
        end
    end

    // Load beats increment; wrap pulse only comes from a real increment off all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_count <= pc_init;
            pc_wrap  <= 1'b0;
        end else begin
            pc_wrap <= 1'b0;
            if (Load_PC) begin
                PC_count <= data_in;
            end else if (Inc_PC) begin
                PC_count <= PC_count + 1'b1;
                pc_wrap  <= (PC_count == all_ones);
            end
        end
    end

    assign R0_out = regs[0];
    assign R1_out = regs[1];
    assign R2_out = regs[2];
    assign R3_out = regs[3];

endmodule

// File: tb/tb_gp_register_bank.sv
// Directed self-checking bench for gp_register_bank (default 8-bit build).
// Expected values are tracked in exp_* and follow MULTI_LOAD_CHECK_EN when defined.
module tb_gp_register_bank;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC;
    logic [7:0] R0_out, R1_out, R2_out, R3_out, PC_count;
    logic       pc_wrap, load_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_r [4];
    logic [7:0] exp_pc;
    logic       exp_wrap;
    logic       exp_err;
    logic [7:0] obs_r [4];

    assign obs_r[0] = R0_out;
    assign obs_r[1] = R1_out;
    assign obs_r[2] = R2_out;
    assign obs_r[3] = R3_out;

    gp_register_bank dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .Load_R0  (Load_R0),
        .Load_R1  (Load_R1),
        .Load_R2  (Load_R2),
        .Load_R3  (Load_R3),
        .Load_PC  (Load_PC),
        .Inc_PC   (Inc_PC),
        .R0_out   (R0_out),
        .R1_out   (R1_out),
        .R2_out   (R2_out),
        .R3_out   (R3_out),
        .PC_count (PC_count),
        .pc_wrap  (pc_wrap),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        Load_R0 = 1'b0; Load_R1 = 1'b0; Load_R2 = 1'b0; Load_R3 = 1'b0;
        Load_PC = 1'b0; Inc_PC  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_in = 8'h00;
        idle_inputs();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_r[i] !== 8'h00) begin
                bad++;
                $display("FAIL reset_r%0d got=%h exp=00", i, obs_r[i]);
            end
        end
        total++;
        if ({PC_count, pc_wrap, load_err} !== {8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_pc_flags got=%h/%b/%b exp=00/0/0", PC_count, pc_wrap, load_err);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) exp_r[i] = 8'h00;
        exp_pc = 8'h00; exp_wrap = 1'b0; exp_err = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        data_in = 8'hA5; Load_R1 = 1'b1;
        @(negedge clk);
        Load_R1 = 1'b0; data_in = 8'h3C; Load_R3 = 1'b1;
        total++;
        if (R1_out !== 8'hA5) begin
            bad++;
            $display("FAIL write_r1_latency got=%h exp=a5", R1_out);
        end
        total++;
        if (R3_out !== 8'h00) begin
            bad++;
            $display("FAIL write_r3_before got=%h exp=00", R3_out);
        end
        @(negedge clk);
        Load_R3 = 1'b0;
        exp_r[1] = 8'hA5; exp_r[3] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_r[i] !== exp_r[i]) begin
                bad++;
                $display("FAIL write_r%0d got=%h exp=%h", i, obs_r[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_pc_priority();
        data_in = 8'h10; Load_PC = 1'b1;
        @(negedge clk);
        Load_PC = 1'b0; Inc_PC = 1'b1;
        total++;
        if (PC_count !== 8'h10) begin
            bad++;
            $display("FAIL pc_load got=%h exp=10", PC_count);
        end
        @(negedge clk);
        total++;
        if (PC_count !== 8'h11) begin
            bad++;
            $display("FAIL pc_inc got=%h exp=11", PC_count);
        end
        data_in = 8'h80; Load_PC = 1'b1; Inc_PC = 1'b1;
        @(negedge clk);
        idle_inputs();
        exp_pc = 8'h80;
`ifdef MULTI_LOAD_CHECK_EN
        exp_err = 1'b1;
`endif
        total++;
        if (PC_count !== exp_pc) begin
            bad++;
            $display("FAIL pc_load_wins got=%h exp=%h", PC_count, exp_pc);
        end
        total++;
        if (load_err !== exp_err || pc_wrap !== 1'b0) begin
            bad++;
            $display("FAIL pc_both_flags got=err%b/wrap%b exp=err%b/wrap0", load_err, pc_wrap, exp_err);
        end
    endtask

    task automatic test_wrap();
        data_in = 8'h00; Load_PC = 1'b1;
        @(negedge clk);
        Load_PC = 1'b0;
        total++;
        if (pc_wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_on_load_zero got=%b exp=0", pc_wrap);
        end
        data_in = 8'hFF; Load_PC = 1'b1;
        @(negedge clk);
        Load_PC = 1'b0; Inc_PC = 1'b1;
        total++;
        if (PC_count !== 8'hFF || pc_wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_pre got=%h/%b exp=ff/0", PC_count, pc_wrap);
        end
        @(negedge clk);
        total++;
        if (PC_count !== 8'h00 || pc_wrap !== 1'b1) begin
            bad++;
            $display("FAIL wrap_edge got=%h/%b exp=00/1", PC_count, pc_wrap);
        end
        @(negedge clk);
        Inc_PC = 1'b0;
        total++;
        if (PC_count !== 8'h01 || pc_wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_post got=%h/%b exp=01/0", PC_count, pc_wrap);
        end
        @(negedge clk);
        total++;
        if (PC_count !== 8'h01 || pc_wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_hold got=%h/%b exp=01/0", PC_count, pc_wrap);
        end
        exp_pc = 8'h01;
    endtask

    task automatic test_multi_load();
        data_in = 8'h11; Load_R0 = 1'b1;
        @(negedge clk);
        Load_R0 = 1'b0; data_in = 8'h22; Load_R2 = 1'b1;
        @(negedge clk);
        Load_R2 = 1'b0;
        exp_r[0] = 8'h11; exp_r[2] = 8'h22;
        total++;
        if (R0_out !== 8'h11 || R2_out !== 8'h22) begin
            bad++;
            $display("FAIL multi_setup got=%h/%h exp=11/22", R0_out, R2_out);
        end
        data_in = 8'h77; Load_R0 = 1'b1; Load_R2 = 1'b1;
        @(negedge clk);
        idle_inputs();
`ifdef MULTI_LOAD_CHECK_EN
        exp_err = 1'b1;
`else
        exp_r[0] = 8'h77; exp_r[2] = 8'h77;
`endif
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_r[i] !== exp_r[i]) begin
                bad++;
                $display("FAIL multi_r%0d got=%h exp=%h", i, obs_r[i], exp_r[i]);
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (load_err !== exp_err) begin
            bad++;
            $display("FAIL multi_err_sticky got=%b exp=%b", load_err, exp_err);
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 20; c++) begin
            data_in = 8'($urandom);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                total++;
                if (obs_r[i] !== exp_r[i]) begin
                    bad++;
                    $display("FAIL hold_r%0d cyc%0d got=%h exp=%h", i, c, obs_r[i], exp_r[i]);
                end
            end
            total++;
            if (PC_count !== exp_pc || pc_wrap !== 1'b0 || load_err !== exp_err) begin
                bad++;
                $display("FAIL hold_pc cyc%0d got=%h/%b/%b exp=%h/0/%b",
                         c, PC_count, pc_wrap, load_err, exp_pc, exp_err);
            end
        end
    endtask

    task automatic test_async_reset();
        data_in = 8'h5A; Load_R2 = 1'b1;
        @(negedge clk);
        Load_R2 = 1'b0; data_in = 8'h33; Load_PC = 1'b1;
        @(negedge clk);
        idle_inputs();
        total++;
        if (R2_out !== 8'h5A || PC_count !== 8'h33) begin
            bad++;
            $display("FAIL areset_setup got=%h/%h exp=5a/33", R2_out, PC_count);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_r[i] !== 8'h00) begin
                bad++;
                $display("FAIL areset_r%0d got=%h exp=00", i, obs_r[i]);
            end
        end
        total++;
        if ({PC_count, pc_wrap, load_err} !== {8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL areset_pc_flags got=%h/%b/%b exp=00/0/0", PC_count, pc_wrap, load_err);
        end
        data_in = 8'h99; Load_R1 = 1'b1; Inc_PC = 1'b1;
        @(negedge clk);
        total++;
        if (R1_out !== 8'h00 || PC_count !== 8'h00) begin
            bad++;
            $display("FAIL areset_overrides got=%h/%h exp=00/00", R1_out, PC_count);
        end
        rst = 1'b1;
        idle_inputs();
        data_in = 8'h42; Load_R0 = 1'b1;
        @(negedge clk);
        idle_inputs();
        total++;
        if (R0_out !== 8'h42 || R1_out !== 8'h00) begin
            bad++;
            $display("FAIL areset_first_edge got=%h/%h exp=42/00", R0_out, R1_out);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_pc_priority();
        test_wrap();
        test_multi_load();
        test_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gp_register_bank.md
Name: gp_register_bank

Overview:
- Holds the four general-purpose registers R0–R3 and the program counter of the RISC-SPM datapath.
- Sits directly upstream of the 5-channel Bus_1 multiplexer:
  - R0_out..R3_out drive mux inputs data_a..data_d.
  - PC_count is the other source the controller routes onto Bus_1.
- Registers are written from Bus_2 under controller load strobes.
- PC supports load and increment, plus wrap and illegal-strobe status flags.

Parameters:
- word_size, 8, width of the data/address bus, the registers and the PC.
- pc_reset_val, 0, value PC_count takes on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- data_in  input  word_size  Bus_2 value to be written.
- Load_R0  input  1  write data_in into R0 at next rising edge.
- Load_R1  input  1  write data_in into R1.
- Load_R2  input  1  write data_in into R2.
- Load_R3  input  1  write data_in into R3.
- Load_PC  input  1  write data_in into PC.
- Inc_PC  input  1  PC increments by 1.
- R0_out  output  word_size  registered R0 (to mux data_a).
- R1_out  output  word_size  registered R1 (data_b).
- R2_out  output  word_size  registered R2 (data_c).
- R3_out  output  word_size  registered R3 (data_d).
- PC_count  output  word_size  registered program counter.
- pc_wrap  output  1  one-cycle pulse: PC incremented from all-ones to zero.
- load_err  output  1  sticky: illegal strobe combination seen.

Behaviour:
- One clock, all state on posedge clk. Reset is asynchronous and active-low: rst low clears state immediately, independent of clk.
- Reset values:
  - R0_out..R3_out = 0.
  - PC_count = pc_reset_val.
  - pc_wrap = 0, load_err = 0.
- Reset asserted mid-operation overrides every strobe. The first edge after rst rises behaves as a normal cycle.
- Register write: each Load_Rn registers data_in into Rn at the edge. Latency is 1 cycle; the new value is visible on Rn_out after the edge. No Load_Rn means the register holds.
- PC priority per edge:
  - Load_PC: PC <= data_in (wins over Inc_PC).
  - else Inc_PC: PC <= PC + 1, modulo 2^word_size.
  - else hold.
- pc_wrap:
  - Goes 1 for exactly the cycle after an edge where Inc_PC was applied (Load_PC low) with PC = all-ones. Otherwise 0.
  - Load_PC of zero does not raise pc_wrap.
- Load_PC and Load_Rn may be asserted in the same cycle. Both write; PC and Rn are independent.
- load_err and the multi-load rule are defined under Optional Feature.
- No combinational path from any input to any output. All outputs are flop outputs.

Optional Feature:
- Macro: MULTI_LOAD_CHECK_EN.
- Defined:
  - If two or more of Load_R0..Load_R3 are high in one cycle, no Rn is written that cycle; all registers hold.
  - load_err sets at that edge and stays 1 until rst.
  - Load_PC and Inc_PC are still honoured normally that cycle.
  - Load_PC and Inc_PC both high also sets load_err. The PC load still occurs (Load_PC wins).
- Not defined:
  - Every asserted Load_Rn writes data_in (broadcast).
  - load_err is tied to 0.

Test Plan:
- Reset: rst low mid-cycle with R2=0x5A, PC=0x33 → all Rn_out=0x00, PC_count=0x00, flags 0 before the next clk edge.
- Write/readback: data_in=0xA5 with Load_R1 for 1 cycle, then data_in=0x3C with Load_R3 → R1_out=0xA5, R3_out=0x3C, R0/R2 stay 0x00.
- PC load vs increment: PC=0x10; cycle 1 Inc_PC → 0x11; cycle 2 Load_PC+Inc_PC with data_in=0x80 → 0x80 (load wins; load_err=1 only with MULTI_LOAD_CHECK_EN).
- Wrap: Load_PC data_in=0xFF, then Inc_PC two cycles → PC 0x00 then 0x01; pc_wrap high exactly one cycle after the 0xFF→0x00 edge.
- Multi-load: Load_R0 and Load_R2 high with data_in=0x77 → with MULTI_LOAD_CHECK_EN: R0, R2 unchanged, load_err=1 sticky until rst. Without: R0=R2=0x77, load_err=0.
- Hold: 20 idle cycles with random data_in and no strobes → all outputs constant.
